// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Purpose:
//   Turns a raw, bouncing push-button or switch level into a clean registered
//   level. The raw input is synchronised first. A new level is accepted only
//   after STABLE_CYCLES consecutive synchronised samples agree with it. Every
//   qualification attempt that gets abandoned is counted in a saturating
//   8-bit glitch counter.
//
// Parameters:
//   STABLE_CYCLES - consecutive synchronised samples needed to accept a
//                   level change (2..65535)
//   SYNC_STAGES   - depth of the input synchroniser chain (2..4)
//
// Ports:
//   clk        - single clock; all state changes on its rising edge
//   rst        - synchronous, active-high reset
//   btn_in     - raw asynchronous button level
//   db_out     - registered debounced level
//   db_busy    - high while a candidate level change is being qualified
//   glitch_cnt - saturating count of aborted level changes
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int STABLE_CYCLES = 1000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       db_out,
    output logic       db_busy,
    output logic [7:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Parameter sanity: a bad configuration stops elaboration instead of
    // quietly building a debouncer that cannot work.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable_cycles
        $error("button_debounce: STABLE_CYCLES must be in 2..65535");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("button_debounce: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_out_q, db_out_d;
    logic [7:0]             glitch_q, glitch_d;
    logic [7:0]             glitch_inc;
    logic                   s;

    // Only the last synchroniser stage is allowed to feed the rest of the
    // logic, so no other path ever sees the raw asynchronous input.
    assign s = sync_q[SYNC_STAGES-1];

    // Next-state logic for the synchroniser and the qualification FSM. The
    // counter counts samples that agree with the candidate level. A single
    // disagreeing sample sends the FSM back to the stable state it came from
    // and keeps no partial credit. The counter tops out at STABLE_CYCLES-1,
    // where the level change completes, so it can never wrap.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], btn_in};
        state_d    = state_q;
        cnt_d      = cnt_q;
        db_out_d   = db_out_q;
        glitch_d   = glitch_q;
        glitch_inc = (glitch_q == 8'hFF) ? glitch_q : glitch_q + 8'd1;

        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = STABLE_HI;
                    db_out_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = STABLE_LO;
                    db_out_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // Corrupted state register: fall back to a known idle low.
                state_d  = STABLE_LO;
                cnt_d    = '0;
                db_out_d = 1'b0;
            end
        endcase
    end

    // All state lives in this one register block. Reset wins over
    // everything, including a half-finished qualification, and an attempt
    // abandoned this way is not counted as a glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            db_out_q <= 1'b0;
            glitch_q <= 8'd0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_out_q <= db_out_d;
            glitch_q <= glitch_d;
        end
    end

    assign db_out     = db_out_q;
    assign db_busy    = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign glitch_cnt = glitch_q;

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000: consecutive synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: depth of the input synchronizer flop chain; legal range 2..4.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port btn_in, input, 1: raw, asynchronous, bouncing push-button/switch level.
REQ-006 SHALL have port db_out, output, 1: registered, debounced level; drives the downstream positive-edge detector input directly.
REQ-007 SHALL have port db_busy, output, 1: high while a candidate level change is being qualified.
REQ-008 SHALL have port glitch_cnt, output, 8: saturating count of rejected (aborted) level changes.

Function
REQ-009 SHALL pass btn_in through SYNC_STAGES flops; s = last flop; only s SHALL feed any other logic.
REQ-010 SHALL implement FSM states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, plus qualification counter cnt of width $clog2(STABLE_CYCLES+1).
REQ-011 STABLE_LO: s=1 -> WAIT_HI, cnt<=1; s=0 -> stay, cnt<=0.
REQ-012 WAIT_HI: s=0 -> STABLE_LO, cnt<=0, glitch_cnt increments; s=1 and cnt=STABLE_CYCLES-1 -> STABLE_HI, db_out<=1, cnt<=0; otherwise s=1 -> cnt<=cnt+1.
REQ-013 STABLE_HI: s=0 -> WAIT_LO, cnt<=1; s=1 -> stay, cnt<=0.
REQ-014 WAIT_LO: mirror of WAIT_HI with s inverted; completion -> STABLE_LO, db_out<=0; abort -> STABLE_HI, glitch_cnt increments.
REQ-015 db_out SHALL change only on the WAIT_HI->STABLE_HI or WAIT_LO->STABLE_LO transitions; single flop output, no combinational path from btn_in.
REQ-016 Latency: btn_in held stable at a new level from before edge 0 SHALL produce db_out change on edge number SYNC_STAGES+STABLE_CYCLES-1 (i.e. the (SYNC_STAGES+STABLE_CYCLES)-th edge).
REQ-017 Any opposite sample of s during WAIT_* SHALL restart qualification from the stable state; no partial credit retained.
REQ-018 db_busy SHALL be a decode of the state register: 1 in WAIT_HI/WAIT_LO, 0 otherwise.
REQ-019 glitch_cnt SHALL saturate at 255 and never wrap; cleared only by rst.
REQ-020 cnt SHALL never exceed STABLE_CYCLES-1; no wrap-around possible.
REQ-021 Illegal/unreachable state encodings SHALL recover to STABLE_LO with db_out=0 on the next edge.
REQ-022 Out-of-range parameters SHALL be flagged by an elaboration-time assertion.

Reset
REQ-023 rst=1 at an edge SHALL set: all sync flops 0, state STABLE_LO, cnt 0, db_out 0, db_busy 0, glitch_cnt 0.
REQ-024 rst SHALL override all FSM activity, including mid-qualification (WAIT_*), with no glitch count recorded for the abandoned attempt.
REQ-025 If btn_in is high while rst deasserts, db_out SHALL rise on the (SYNC_STAGES+STABLE_CYCLES)-th edge after the first edge with rst=0.

Verification (bench uses STABLE_CYCLES=4, SYNC_STAGES=2)
REQ-026 Clean press: btn_in 0->1 before edge 0, held -> db_out=1 after edge 5, db_busy=1 after edges 2..4, glitch_cnt=0.
REQ-027 Short glitch: btn_in high for 3 cycles then low -> db_out stays 0, glitch_cnt=1, db_busy returns to 0.
REQ-028 Bouncing press: 5 alternating 1-cycle pulses then steady 1 -> db_out rises exactly 6 edges after the final rising transition of btn_in; glitch_cnt counts each abort.
REQ-029 Release: from db_out=1, btn_in 1->0 held -> db_out=0 after 6 edges; downstream edge detector produces no pulse.
REQ-030 Saturation: 300 forced aborts -> glitch_cnt=255, not 44.
REQ-031 Reset mid-WAIT_HI (cnt=2) -> next edge: state STABLE_LO, db_out=0, cnt=0, glitch_cnt=0; held btn_in re-qualifies per REQ-025.
